// File: rtl/k_fetch_unit.sv
// k_fetch_unit: single-issue instruction fetch with a ready/valid output stage, halt on HALT_INSN and redirect.
module k_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          PC_W      = 32,
  parameter logic [31:0] HALT_INSN = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t          state;
  logic [PC_W-1:0] pc;
  logic            fetch, xfer, redirect;
  assign address  = 32'(pc);
  assign busy     = state != IDLE;
  assign redirect = redirect_valid && state != IDLE;
  assign xfer     = out_valid && out_ready;
  assign fetch    = state == RUN && !redirect_valid && (!out_valid || out_ready);
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC[PC_W-1:0];
      out_valid   <= 1'b0;
      out_insn    <= '0;
      out_pc      <= '0;
      fetch_count <= '0;
    end else begin
      // a transfer in a redirect cycle still counts; only the next word is discarded
      if (xfer && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      if (redirect) begin
        pc        <= redirect_pc[PC_W-1:0];
        out_valid <= 1'b0;
        state     <= RUN;
      end else if (fetch) begin
        out_insn  <= instruction;
        out_pc    <= 32'(pc);
        out_valid <= 1'b1;
        if (instruction == HALT_INSN) state <= HALTED;
        else pc <= pc + PC_W'(1);
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (state == IDLE && start) state <= RUN;
    end
  end
endmodule

// File: doc/k_fetch_unit.md
K_FETCH_UNIT -- requirements
Module: k_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0, start word address after reset.
REQ-002 The block SHALL have parameter PC_W, default 32, program-counter width; legal range 4..32.
REQ-003 The block SHALL have parameter HALT_INSN, default 32'hFFFF_FFFF, encoding that stops fetch.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, both listed first below.
REQ-005 clk  input  1  sole clock, rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle pulse that begins fetching from IDLE.
REQ-008 address  output  32  word address to K_InstructionMemory, zero-extended PC.
REQ-009 instruction  input  32  combinational read data from K_InstructionMemory for the current address.
REQ-010 redirect_valid  input  1  branch/jump request.
REQ-011 redirect_pc  input  32  redirect target; low PC_W bits used.
REQ-012 out_valid  output  1  out_insn and out_pc hold a fetched instruction.
REQ-013 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-014 out_insn  output  32  fetched instruction word.
REQ-015 out_pc  output  32  zero-extended address out_insn was fetched from.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 fetch_count  output  32  number of completed transfers, saturating at 32'hFFFF_FFFF.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and HALTED.
REQ-019 Transitions SHALL be: IDLE->RUN on start; RUN->HALTED on a fetch of HALT_INSN; HALTED->RUN on redirect_valid; RUN and HALTED ignore start; IDLE ignores redirect_valid.
REQ-020 address SHALL equal the PC register combinationally, giving zero added latency; instruction is sampled in the same cycle.
REQ-021 A fetch SHALL occur on a rising edge when state==RUN, redirect_valid==0 and (out_valid==0 or out_ready==1).
REQ-022 On a fetch, the block SHALL update out_insn<=instruction, out_pc<=PC, out_valid<=1 and PC<=PC+1 modulo 2^PC_W; PC wraps from 2^PC_W-1 to 0.
REQ-023 The throughput SHALL be one instruction per cycle while out_ready is held high; first out_valid is asserted one cycle after the start edge.
REQ-024 When out_valid==1 and out_ready==0, the block SHALL hold out_insn, out_pc, out_valid and PC stable.
REQ-025 When a transfer occurs and no fetch occurs in the same cycle, the block SHALL set out_valid<=0.
REQ-026 A fetch of HALT_INSN SHALL be presented on the output like any other instruction, with PC not incremented and state<=HALTED; no fetch occurs in HALTED.
REQ-027 redirect_valid in RUN or HALTED SHALL have the highest priority: PC<=redirect_pc[PC_W-1:0], out_valid<=0 (pending word discarded, not counted), no fetch that cycle, and state<=RUN.
REQ-028 Redirect and transfer in the same cycle SHALL count the transfer, then discard per REQ-027.
REQ-029 fetch_count SHALL increment by 1 per transfer and hold at 32'hFFFF_FFFF.

Reset
REQ-030 On reset, the block SHALL set state=IDLE, PC=RESET_PC[PC_W-1:0], out_valid=0, out_insn=0, out_pc=0 and fetch_count=0; busy=0 and address=RESET_PC.
REQ-031 Reset SHALL override all other inputs in the same cycle; reset mid-stall or mid-redirect discards the pending output with no transfer counted.

Verification
REQ-032 Stream: memory words 0..3 = A0,A1,A2,A3; start with out_ready=1 -> out_insn A0,A1,A2,A3 on consecutive cycles with out_pc 0,1,2,3, and fetch_count=4.
REQ-033 Stall: out_ready=0 for 3 cycles after A1 is presented -> A1/out_pc=1 held, address=2 stable; release -> A2 next cycle, no loss or duplication.
REQ-034 Redirect: redirect_valid with redirect_pc=0x10 while A2 is pending and stalled -> out_valid=0 next cycle, A2 not counted, next out_pc=0x10.
REQ-035 Halt: word 5 = HALT_INSN -> HALT_INSN delivered with out_pc=5, state HALTED, address stays 5, busy=1; redirect to 0 -> resumes with out_pc=0.
REQ-036 Wrap: PC_W=4 with PC at 15 -> out_pc 15 then 0.
REQ-037 Reset mid-run: reset asserted during a stall -> all outputs at REQ-030 values next cycle, and start restarts at RESET_PC.
